// File: rtl/operand_read_unit.sv
// operand_read_unit
// Dual-lane register-read stage. Owns the 8 x 16-bit architectural register
// file, accepts up to two decoded instructions per cycle and returns their
// source operands one cycle later. A pending-write scoreboard holds back any
// lane whose sources or destination are still in flight. An intra-bundle
// dependency splits the bundle: lane 1 issues first, lane 2 follows later
// from a holding register.
//
// Optional feature: define OPREAD_WB_BYPASS_EN to forward same-cycle writeback
// data into operand reads and let same-cycle scoreboard clears unblock issue.
module operand_read_unit (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid1,
    input  logic         valid2,
    input  logic [15:0]  instr1,
    input  logic [15:0]  instr2,
    input  logic         wr1,
    input  logic         wr2,
    input  logic         stall,
    output logic         ready,
    input  logic         iswb_a,
    input  logic         isld_a,
    input  logic [15:0]  instr_a,
    input  logic [15:0]  ldresult_a,
    input  logic [15:0]  aluresult_a,
    input  logic         iswb_b,
    input  logic         isld_b,
    input  logic [15:0]  instr_b,
    input  logic [15:0]  ldresult_b,
    input  logic [15:0]  aluresult_b,
    output logic         ovalid1,
    output logic         ovalid2,
    output logic [15:0]  oinstr1,
    output logic [15:0]  oinstr2,
    output logic [15:0]  opa1,
    output logic [15:0]  opb1,
    output logic [15:0]  opa2,
    output logic [15:0]  opb2,
    output logic [127:0] regval
);

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_e;

    // Writeback lane decode: destination and selected result.
    logic [2:0]  wb_dst_a, wb_dst_b;
    logic [15:0] wb_data_a, wb_data_b;
    assign wb_dst_a  = instr_a[10:8];
    assign wb_dst_b  = instr_b[10:8];
    assign wb_data_a = isld_a ? ldresult_a : aluresult_a;
    assign wb_data_b = isld_b ? ldresult_b : aluresult_b;

    // Only the destination field of a writeback instruction matters here.
    logic unused_wb_bits;
    assign unused_wb_bits = ^{instr_a[15:11], instr_a[7:0], instr_b[15:11], instr_b[7:0]};

    state_e      state_q, state_d;
    logic [15:0] rf_q [8];
    logic [15:0] rf_d [8];
    logic [7:0]  pend_q, pend_d;
    logic [15:0] hold_instr_q, hold_instr_d;
    logic        hold_wr_q, hold_wr_d;
    logic        ovalid1_q, ovalid1_d, ovalid2_q, ovalid2_d;
    logic [15:0] oinstr1_q, oinstr1_d, oinstr2_q, oinstr2_d;
    logic [15:0] opa1_q, opa1_d, opb1_q, opb1_d;
    logic [15:0] opa2_q, opa2_d, opb2_q, opb2_d;

    logic [7:0]  clr_mask, set_mask, pend_view;
    logic [15:0] rd_view [8];
    logic        blk1, blk2, blk_hold, hazard;
    logic        iss1, iss2, iss_held;

    // Scoreboard clears: one bit per writeback lane landing at this edge.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        clr_mask = '0;
        if (iswb_a) clr_mask[wb_dst_a] = 1'b1;
        if (iswb_b) clr_mask[wb_dst_b] = 1'b1;
    end

`ifdef OPREAD_WB_BYPASS_EN
    assign pend_view = pend_q & ~clr_mask;
`else
    assign pend_view = pend_q;
`endif

    // Operand read view: register file, optionally overlaid by writeback data (lane B last, so it wins).
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            rd_view[i] = rf_q[i];
`ifdef OPREAD_WB_BYPASS_EN
            if (iswb_a && wb_dst_a == 3'(i)) rd_view[i] = wb_data_a;
            if (iswb_b && wb_dst_b == 3'(i)) rd_view[i] = wb_data_b;
`endif
        end
    end

    function automatic logic lane_blocked(input logic [15:0] ins, input logic wr,
                                          input logic [7:0] pv);
        return pv[ins[7:5]] | pv[ins[4:2]] | (wr & pv[ins[10:8]]);
    endfunction

    assign blk1     = lane_blocked(instr1, wr1, pend_view);
    assign blk2     = lane_blocked(instr2, wr2, pend_view);
    assign blk_hold = lane_blocked(hold_instr_q, hold_wr_q, pend_view);

    // Lane 2 depends on lane 1's destination: the bundle has to be split.
    assign hazard = valid1 & valid2 & wr1 &
                    ((instr1[10:8] == instr2[7:5]) |
                     (instr1[10:8] == instr2[4:2]) |
                     (wr2 & (instr1[10:8] == instr2[10:8])));

    // FSM next state, accept decision and lane issue selection.
    always_comb begin
        state_d      = state_q;
        hold_instr_d = hold_instr_q;
        hold_wr_d    = hold_wr_q;
        ready        = 1'b0;
        iss1         = 1'b0;
        iss2         = 1'b0;
        iss_held     = 1'b0;
        case (state_q)
            IDLE: begin
                ready = !stall && !blk1 && (!valid2 || !blk2 || hazard);
                if (ready) begin
                    iss1 = valid1;
                    if (hazard) begin
                        hold_instr_d = instr2;
                        hold_wr_d    = wr2;
                        state_d      = SPLIT;
                    end else begin
                        iss2 = valid2;
                    end
                end
            end
            SPLIT: begin
                if (!stall && !blk_hold) begin
                    iss_held = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Scoreboard update: issued writers set their bit; a set beats a same-cycle clear.
    always_comb begin
        set_mask = '0;
        if (iss1 && wr1)                set_mask[instr1[10:8]]       = 1'b1;
        if (iss2 && wr2)                set_mask[instr2[10:8]]       = 1'b1;
        if (iss_held && hold_wr_q)      set_mask[hold_instr_q[10:8]] = 1'b1;
        pend_d = (pend_q & ~clr_mask) | set_mask;
    end

    // Register file writes: lane B applied after lane A so it wins a shared destination.
    always_comb begin
        for (int i = 0; i < 8; i++) rf_d[i] = rf_q[i];
        if (iswb_a) rf_d[wb_dst_a] = wb_data_a;
        if (iswb_b) rf_d[wb_dst_b] = wb_data_b;
    end

    // Output stage: hold under stall, otherwise capture issued lanes and drop the rest.
    always_comb begin
        ovalid1_d = ovalid1_q;
        ovalid2_d = ovalid2_q;
        oinstr1_d = oinstr1_q;
        oinstr2_d = oinstr2_q;
        opa1_d    = opa1_q;
        opb1_d    = opb1_q;
        opa2_d    = opa2_q;
        opb2_d    = opb2_q;
        if (!stall) begin
            ovalid1_d = iss1;
            ovalid2_d = iss2 | iss_held;
            if (iss1) begin
                oinstr1_d = instr1;
                opa1_d    = rd_view[instr1[7:5]];
                opb1_d    = rd_view[instr1[4:2]];
            end
            if (iss2) begin
                oinstr2_d = instr2;
                opa2_d    = rd_view[instr2[7:5]];
                opb2_d    = rd_view[instr2[4:2]];
            end else if (iss_held) begin
                oinstr2_d = hold_instr_q;
                opa2_d    = rd_view[hold_instr_q[7:5]];
                opb2_d    = rd_view[hold_instr_q[4:2]];
            end
        end
    end

    // Control and output state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pend_q       <= '0;
            hold_instr_q <= '0;
            hold_wr_q    <= 1'b0;
            ovalid1_q    <= 1'b0;
            ovalid2_q    <= 1'b0;
            oinstr1_q    <= '0;
            oinstr2_q    <= '0;
            opa1_q       <= '0;
            opb1_q       <= '0;
            opa2_q       <= '0;
            opb2_q       <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments; combinational blocks above use blocking.
            state_q      <= state_d;
            pend_q       <= pend_d;
            hold_instr_q <= hold_instr_d;
            hold_wr_q    <= hold_wr_d;
            ovalid1_q    <= ovalid1_d;
            ovalid2_q    <= ovalid2_d;
            oinstr1_q    <= oinstr1_d;
            oinstr2_q    <= oinstr2_d;
            opa1_q       <= opa1_d;
            opb1_q       <= opb1_d;
            opa2_q       <= opa2_d;
            opb2_q       <= opb2_d;
        end
    end

    // Architectural register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this small flop-based file is architecturally visible, so it is reset; a RAM macro would not be.
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
        end else begin
            for (int i = 0; i < 8; i++) rf_q[i] <= rf_d[i];
        end
    end

    // Register snapshot {r7, ..., r0}.
    always_comb begin
        regval = '0;
        for (int i = 0; i < 8; i++) regval[i*16 +: 16] = rf_q[i];
    end

    assign ovalid1 = ovalid1_q;
    assign ovalid2 = ovalid2_q;
    assign oinstr1 = oinstr1_q;
    assign oinstr2 = oinstr2_q;
    assign opa1    = opa1_q;
    assign opb1    = opb1_q;
    assign opa2    = opa2_q;
    assign opb2    = opb2_q;

endmodule

// File: tb/tb_operand_read_unit.sv
// Self-checking bench for operand_read_unit: directed scenarios followed by
// randomized bundles and writebacks, all compared against a behavioural model
// built from the stage's issue, scoreboard and writeback rules.
module tb_operand_read_unit;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid1, valid2, wr1, wr2, stall;
    logic [15:0]  instr1, instr2;
    logic         ready;
    logic         iswb_a, isld_a, iswb_b, isld_b;
    logic [15:0]  instr_a, ldresult_a, aluresult_a;
    logic [15:0]  instr_b, ldresult_b, aluresult_b;
    logic         ovalid1, ovalid2;
    logic [15:0]  oinstr1, oinstr2, opa1, opb1, opa2, opb2;
    logic [127:0] regval;

    always #5 clk = ~clk;

    operand_read_unit dut (
        .clk(clk), .rst_n(rst_n),
        .valid1(valid1), .valid2(valid2), .instr1(instr1), .instr2(instr2),
        .wr1(wr1), .wr2(wr2), .stall(stall), .ready(ready),
        .iswb_a(iswb_a), .isld_a(isld_a), .instr_a(instr_a),
        .ldresult_a(ldresult_a), .aluresult_a(aluresult_a),
        .iswb_b(iswb_b), .isld_b(isld_b), .instr_b(instr_b),
        .ldresult_b(ldresult_b), .aluresult_b(aluresult_b),
        .ovalid1(ovalid1), .ovalid2(ovalid2), .oinstr1(oinstr1), .oinstr2(oinstr2),
        .opa1(opa1), .opb1(opb1), .opa2(opa2), .opb2(opb2), .regval(regval)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit last_ready;
    bit need_new;

    // Reference model state.
    logic [15:0] m_rf [8];
    bit          m_pend [8];
    bit          m_split;
    logic [15:0] m_held;
    bit          m_held_wr;
    bit          m_ov1, m_ov2;
    logic [15:0] m_oi1, m_oi2, m_opa1, m_opb1, m_opa2, m_opb2;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_rf[i]   = '0;
            m_pend[i] = 1'b0;
        end
        m_split = 0; m_held = '0; m_held_wr = 0;
        m_ov1 = 0; m_ov2 = 0;
        m_oi1 = '0; m_oi2 = '0; m_opa1 = '0; m_opb1 = '0; m_opa2 = '0; m_opb2 = '0;
    endtask

    function automatic logic [15:0] m_read(input logic [2:0] idx);
        logic [15:0] v;
        v = m_rf[idx];
`ifdef OPREAD_WB_BYPASS_EN
        if (iswb_a && instr_a[10:8] == idx) v = isld_a ? ldresult_a : aluresult_a;
        if (iswb_b && instr_b[10:8] == idx) v = isld_b ? ldresult_b : aluresult_b;
`endif
        return v;
    endfunction

    function automatic bit m_busy(input logic [2:0] idx);
        bit b;
        b = m_pend[idx];
`ifdef OPREAD_WB_BYPASS_EN
        if ((iswb_a && instr_a[10:8] == idx) || (iswb_b && instr_b[10:8] == idx)) b = 0;
`endif
        return b;
    endfunction

    function automatic bit m_blocked(input logic [15:0] ins, input bit wr);
        return m_busy(ins[7:5]) || m_busy(ins[4:2]) || (wr && m_busy(ins[10:8]));
    endfunction

    function automatic logic [127:0] m_regval();
        logic [127:0] r;
        for (int i = 0; i < 8; i++) r[i*16 +: 16] = m_rf[i];
        return r;
    endfunction

    // What the stage decides this cycle given current inputs and model state.
    task automatic model_eval(output bit rdy, output bit i1, output bit i2,
                              output bit go_split, output bit ih);
        bit hz;
        rdy = 0; i1 = 0; i2 = 0; go_split = 0; ih = 0;
        if (!m_split) begin
            hz = valid1 && valid2 && wr1 &&
                 (instr1[10:8] == instr2[7:5] || instr1[10:8] == instr2[4:2] ||
                  (wr2 && instr1[10:8] == instr2[10:8]));
            rdy = !stall && !m_blocked(instr1, wr1) && (!valid2 || !m_blocked(instr2, wr2) || hz);
            i1 = rdy && valid1;
            i2 = rdy && valid2 && !hz;
            go_split = rdy && hz;
        end else begin
            ih = !stall && !m_blocked(m_held, m_held_wr);
        end
    endtask

    // Advance the model across one rising edge.
    task automatic model_commit();
        bit rdy, i1, i2, gs, ih;
        bit set_bits [8];
        model_eval(rdy, i1, i2, gs, ih);
        for (int i = 0; i < 8; i++) set_bits[i] = 0;
        if (!stall) begin
            m_ov1 = i1;
            m_ov2 = i2 || ih;
            if (i1) begin
                m_oi1 = instr1; m_opa1 = m_read(instr1[7:5]); m_opb1 = m_read(instr1[4:2]);
            end
            if (i2) begin
                m_oi2 = instr2; m_opa2 = m_read(instr2[7:5]); m_opb2 = m_read(instr2[4:2]);
            end
            if (ih) begin
                m_oi2 = m_held; m_opa2 = m_read(m_held[7:5]); m_opb2 = m_read(m_held[4:2]);
            end
        end
        if (i1 && wr1) set_bits[instr1[10:8]] = 1;
        if (i2 && wr2) set_bits[instr2[10:8]] = 1;
        if (ih && m_held_wr) set_bits[m_held[10:8]] = 1;
        if (gs) begin
            m_split = 1; m_held = instr2; m_held_wr = wr2;
        end
        if (ih) m_split = 0;
        if (iswb_a) m_rf[instr_a[10:8]] = isld_a ? ldresult_a : aluresult_a;
        if (iswb_b) m_rf[instr_b[10:8]] = isld_b ? ldresult_b : aluresult_b;
        if (iswb_a) m_pend[instr_a[10:8]] = 0;
        if (iswb_b) m_pend[instr_b[10:8]] = 0;
        for (int i = 0; i < 8; i++) if (set_bits[i]) m_pend[i] = 1;
    endtask

    task automatic check_all();
        check("ovalid1", 128'(ovalid1), 128'(m_ov1));
        check("ovalid2", 128'(ovalid2), 128'(m_ov2));
        check("oinstr1", 128'(oinstr1), 128'(m_oi1));
        check("oinstr2", 128'(oinstr2), 128'(m_oi2));
        check("opa1", 128'(opa1), 128'(m_opa1));
        check("opb1", 128'(opb1), 128'(m_opb1));
        check("opa2", 128'(opa2), 128'(m_opa2));
        check("opb2", 128'(opb2), 128'(m_opb2));
        check("regval", regval, m_regval());
    endtask

    // One clock: check ready mid-cycle, then outputs just after the edge.
    task automatic step();
        bit r, a, b, c, d;
        @(negedge clk);
        model_eval(r, a, b, c, d);
        last_ready = ready;
        check("ready", 128'(ready), 128'(r));
        @(posedge clk);
        model_commit();
        #1;
        check_all();
    endtask

    task automatic clear_wb();
        iswb_a = 0; isld_a = 0; instr_a = '0; ldresult_a = '0; aluresult_a = '0;
        iswb_b = 0; isld_b = 0; instr_b = '0; ldresult_b = '0; aluresult_b = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1; valid1 = 0; valid2 = 0; wr1 = 0; wr2 = 0; stall = 0;
        instr1 = '0; instr2 = '0;
        clear_wb();

        // Reset state.
        #2 rst_n = 0;
        #1;
        model_reset();
        check_all();
        check("rst_ready", 128'(ready), 128'(1));
        @(negedge clk); #1 rst_n = 1;
        @(posedge clk); model_commit(); #1;

        // Hazard bundle: r1 <- (r1,r0) then r2 <- (r2,r1); lane 2 waits on r1.
        valid1 = 1; instr1 = 16'h0120; wr1 = 1;
        valid2 = 1; instr2 = 16'h0244; wr2 = 1;
        step();
        check("t1_ready", 128'(last_ready), 128'(1));
        check("t1_ov1", 128'(ovalid1), 128'(1));
        check("t1_ov2", 128'(ovalid2), 128'(0));
        valid1 = 0; valid2 = 0; wr1 = 0; wr2 = 0;
        step();
        check("t1_ov2_hold_a", 128'(ovalid2), 128'(0));
        step();
        check("t1_ov2_hold_b", 128'(ovalid2), 128'(0));
        iswb_a = 1; instr_a = 16'h0100; aluresult_a = 16'h1234;
        step();
        clear_wb();
`ifdef OPREAD_WB_BYPASS_EN
        check("t1_split_ov2", 128'(ovalid2), 128'(1));
`else
        check("t1_split_ov2_early", 128'(ovalid2), 128'(0));
        step();
        check("t1_split_ov2", 128'(ovalid2), 128'(1));
`endif
        check("t1_split_ov1", 128'(ovalid1), 128'(0));
        check("t1_split_opb2", 128'(opb2), 128'(16'h1234));
        check("t1_split_oi2", 128'(oinstr2), 128'(16'h0244));

        // r3 <- 0xBEEF via load result; r2 released by lane B.
        iswb_a = 1; isld_a = 1; instr_a = 16'h0300; ldresult_a = 16'hBEEF; aluresult_a = 16'h5555;
        iswb_b = 1; instr_b = 16'h0200; aluresult_b = 16'h0002;
        step();
        clear_wb();
        check("t2_r3", 128'(regval[63:48]), 128'(16'hBEEF));
        valid1 = 1; instr1 = 16'h006C; wr1 = 0;
        step();
        valid1 = 0;
        check("t2_ov1", 128'(ovalid1), 128'(1));
        check("t2_opa1", 128'(opa1), 128'(16'hBEEF));
        check("t2_opb1", 128'(opb1), 128'(16'hBEEF));

        // Both writeback lanes target r5: lane B wins.
        iswb_a = 1; instr_a = 16'h0500; aluresult_a = 16'h1111;
        iswb_b = 1; instr_b = 16'h0500; aluresult_b = 16'h2222;
        step();
        clear_wb();
        check("t3_r5", 128'(regval[95:80]), 128'(16'h2222));

        // Producer of r4, then a consumer held off until writeback.
        valid1 = 1; instr1 = 16'h0400; wr1 = 1;
        step();
        instr1 = 16'h0080; wr1 = 0;
        step();
        check("t4_blk_a", 128'(last_ready), 128'(0));
        step();
        check("t4_blk_b", 128'(last_ready), 128'(0));
        iswb_a = 1; instr_a = 16'h0400; aluresult_a = 16'h00AA;
        step();
        clear_wb();
`ifndef OPREAD_WB_BYPASS_EN
        check("t4_blk_wb", 128'(last_ready), 128'(0));
        step();
`endif
        check("t4_ready", 128'(last_ready), 128'(1));
        check("t4_ov1", 128'(ovalid1), 128'(1));
        check("t4_opa1", 128'(opa1), 128'(16'h00AA));
        valid1 = 0;

        // Stall for three cycles after an accept.
        valid1 = 1; instr1 = 16'h006C; wr1 = 0;
        valid2 = 1; instr2 = 16'h0050; wr2 = 0;
        step();
        check("t5_acc", 128'(last_ready), 128'(1));
        check("t5_opb2", 128'(opb2), 128'(16'h00AA));
        stall = 1; instr1 = 16'h00A4; valid2 = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t5_stall_ready", 128'(last_ready), 128'(0));
            check("t5_stall_oi1", 128'(oinstr1), 128'(16'h006C));
            check("t5_stall_ov2", 128'(ovalid2), 128'(1));
            check("t5_stall_opa2", 128'(opa2), 128'(16'h0002));
        end
        stall = 0;
        step();
        valid1 = 0;
        check("t5_go_ready", 128'(last_ready), 128'(1));
        check("t5_go_oi1", 128'(oinstr1), 128'(16'h00A4));
        check("t5_go_opa1", 128'(opa1), 128'(16'h2222));
        check("t5_go_opb1", 128'(opb1), 128'(16'h1234));
        check("t5_go_ov2", 128'(ovalid2), 128'(0));

        // Reset while a split lane 2 is parked.
        valid1 = 1; instr1 = 16'h0120; wr1 = 1;
        valid2 = 1; instr2 = 16'h0244; wr2 = 1;
        step();
        valid1 = 0; valid2 = 0; wr1 = 0; wr2 = 0;
        step();
        rst_n = 0;
        #1;
        model_reset();
        check_all();
        check("t6_rst_regval", regval, 128'(0));
        check("t6_rst_ov1", 128'(ovalid1), 128'(0));
        @(negedge clk); #1 rst_n = 1;
        @(posedge clk); model_commit(); #1;
        valid1 = 1; instr1 = 16'h0020; wr1 = 0;
        step();
        valid1 = 0;
        check("t6_idle_ready", 128'(last_ready), 128'(1));
        check("t6_ov1", 128'(ovalid1), 128'(1));
        check("t6_opa1", 128'(opa1), 128'(0));

        // Randomized bundles, stalls and writebacks.
        need_new = 1;
        for (int c = 0; c < 400; c++) begin
            if (need_new) begin
                valid1 = ($urandom_range(0, 3) != 0);
                valid2 = ($urandom_range(0, 3) != 0);
                instr1 = 16'($urandom);
                instr2 = 16'($urandom);
                wr1    = 1'($urandom_range(0, 1));
                wr2    = 1'($urandom_range(0, 1));
            end
            stall       = ($urandom_range(0, 4) == 0);
            iswb_a      = ($urandom_range(0, 2) == 0);
            isld_a      = 1'($urandom_range(0, 1));
            instr_a     = 16'($urandom);
            ldresult_a  = 16'($urandom);
            aluresult_a = 16'($urandom);
            iswb_b      = ($urandom_range(0, 2) == 0);
            isld_b      = 1'($urandom_range(0, 1));
            instr_b     = 16'($urandom);
            ldresult_b  = 16'($urandom);
            aluresult_b = 16'($urandom);
            step();
            need_new = last_ready;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
